// File: rtl/reg_scoreboard.sv
// Register scoreboard for the ID stage.
// Each architectural register (except x0) has a small counter of writes that
// have issued but not yet been retired or killed. A non-zero count on a
// source register is a RAW hazard. A saturated count on the destination
// stalls issue so that the counter can never wrap.
module reg_scoreboard #(
    parameter int NumRegs  = 32,
    parameter int CntWidth = 2,
    parameter int RegBits  = $clog2(NumRegs)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [RegBits-1:0]          rs1,
    input  logic                        rs1_valid,
    input  logic [RegBits-1:0]          rs2,
    input  logic                        rs2_valid,
    input  logic [RegBits-1:0]          rd,
    input  logic                        rd_valid,
    input  logic                        issue,
    input  logic [RegBits-1:0]          retire_rd,
    input  logic                        retire_valid,
    input  logic [RegBits-1:0]          kill_rd,
    input  logic                        kill_valid,
    output logic                        dep_found,
    output logic [NumRegs-1:0]          busy,
    output logic [CntWidth+RegBits-1:0] inflight,
    output logic                        error
);

    localparam int InfW = CntWidth + RegBits;
    localparam logic [CntWidth-1:0] CntMax = '1;

    // Read view of every counter; entry 0 is tied to zero.
    logic [CntWidth-1:0] count [NumRegs];
    logic [NumRegs-1:0]  under;

    logic [InfW-1:0] inflight_reg;
    logic [InfW:0]   inflight_next;
    logic            error_reg;
    logic            inc;
    logic            dec_r;
    logic            dec_k;

    // Hazard check looks only at registered counts, so same-cycle
    // issue/retire/kill are not visible until the following cycle.
    always_comb begin
        dep_found = 1'b0;
        if (rs1_valid && rs1 != '0 && count[rs1] != '0) dep_found = 1'b1;
        if (rs2_valid && rs2 != '0 && count[rs2] != '0) dep_found = 1'b1;
        if (rd_valid  && rd  != '0 && count[rd] == CntMax) dep_found = 1'b1;
    end

    // An issue is only counted when it is not hazarded; writes to x0 vanish.
    assign inc   = issue && rd_valid && (rd != '0) && !dep_found;
    assign dec_r = retire_valid && (retire_rd != '0);
    assign dec_k = kill_valid && (kill_rd != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NumRegs; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign count[gi] = '0;
                assign under[gi] = 1'b0;
                assign busy[gi]  = 1'b0;
            end else begin : g_track
                logic [CntWidth-1:0] cnt_reg;
                logic [CntWidth:0]   cnt_sum;
                logic                hit_i;
                logic                hit_r;
                logic                hit_k;

                assign hit_i = inc   && (rd == RegBits'(gi));
                assign hit_r = dec_r && (retire_rd == RegBits'(gi));
                assign hit_k = dec_k && (kill_rd == RegBits'(gi));

                // One extra bit: the top bit set means the net result went
                // negative (the positive range never reaches it).
                assign cnt_sum = {1'b0, cnt_reg}
                               + {{CntWidth{1'b0}}, hit_i}
                               - {{CntWidth{1'b0}}, hit_r}
                               - {{CntWidth{1'b0}}, hit_k};

                assign under[gi] = cnt_sum[CntWidth];
                assign count[gi] = cnt_reg;
                assign busy[gi]  = (cnt_reg != '0);

                // Per-register pending counter, clamped at zero on underflow.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        cnt_reg <= '0;
                    end else if (cnt_sum[CntWidth]) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_sum[CntWidth-1:0];
                    end
                end
            end
        end
    endgenerate

    // Total outstanding writes uses the same net delta; top bit flags negative.
    assign inflight_next = {1'b0, inflight_reg}
                         + {{InfW{1'b0}}, inc}
                         - {{InfW{1'b0}}, dec_r}
                         - {{InfW{1'b0}}, dec_k};

    // Aggregate in-flight counter with clamp-to-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg <= '0;
        end else if (inflight_next[InfW]) begin
            inflight_reg <= '0;
        end else begin
            inflight_reg <= inflight_next[InfW-1:0];
        end
    end

    // Sticky protocol error: hazarded issue or any counter underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            error_reg <= 1'b0;
        end else if ((issue && dep_found) || (|under) || inflight_next[InfW]) begin
            error_reg <= 1'b1;
        end
    end

    assign inflight = inflight_reg;
    assign error    = error_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed testbench for reg_scoreboard with default parameters.
module tb_reg_scoreboard;

    localparam int NumRegs  = 32;
    localparam int CntWidth = 2;
    localparam int RegBits  = 5;

    logic                        clk;
    logic                        rst;
    logic [RegBits-1:0]          rs1;
    logic                        rs1_valid;
    logic [RegBits-1:0]          rs2;
    logic                        rs2_valid;
    logic [RegBits-1:0]          rd;
    logic                        rd_valid;
    logic                        issue;
    logic [RegBits-1:0]          retire_rd;
    logic                        retire_valid;
    logic [RegBits-1:0]          kill_rd;
    logic                        kill_valid;
    logic                        dep_found;
    logic [NumRegs-1:0]          busy;
    logic [CntWidth+RegBits-1:0] inflight;
    logic                        error;

    int pass_cnt  = 0;
    int total_cnt = 0;

    reg_scoreboard #(
        .NumRegs  (NumRegs),
        .CntWidth (CntWidth)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1          (rs1),
        .rs1_valid    (rs1_valid),
        .rs2          (rs2),
        .rs2_valid    (rs2_valid),
        .rd           (rd),
        .rd_valid     (rd_valid),
        .issue        (issue),
        .retire_rd    (retire_rd),
        .retire_valid (retire_valid),
        .kill_rd      (kill_rd),
        .kill_valid   (kill_valid),
        .dep_found    (dep_found),
        .busy         (busy),
        .inflight     (inflight),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0; rs1 = '0; rs1_valid = 1'b0; rs2 = '0; rs2_valid = 1'b0;
        rd = '0; rd_valid = 1'b0; issue = 1'b0;
        retire_rd = '0; retire_valid = 1'b0; kill_rd = '0; kill_valid = 1'b0;
    endtask

    // Apply current inputs for one rising edge, then settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic issue_rd(input logic [RegBits-1:0] r);
        idle();
        rd = r; rd_valid = 1'b1; issue = 1'b1;
        tick();
        idle();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        total_cnt++; if (dep_found !== 1'b0) $display("FAIL reset_dep: got %b want 0", dep_found); else pass_cnt++;
        total_cnt++; if (busy !== '0) $display("FAIL reset_busy: got %h want 0", busy); else pass_cnt++;
        total_cnt++; if (inflight !== '0) $display("FAIL reset_inflight: got %0d want 0", inflight); else pass_cnt++;
        total_cnt++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_raw();
        do_reset();
        issue_rd(5'd5);
        rs1 = 5'd5; rs1_valid = 1'b1;
        #1;
        total_cnt++; if (dep_found !== 1'b1) $display("FAIL raw_rs1_dep: got %b want 1", dep_found); else pass_cnt++;
        total_cnt++; if (busy !== 32'h0000_0020) $display("FAIL raw_busy: got %h want 00000020", busy); else pass_cnt++;
        total_cnt++; if (inflight !== 7'd1) $display("FAIL raw_inflight: got %0d want 1", inflight); else pass_cnt++;
        rs2 = 5'd5; rs2_valid = 1'b1; rs1_valid = 1'b0;
        #1;
        total_cnt++; if (dep_found !== 1'b1) $display("FAIL raw_rs2_dep: got %b want 1", dep_found); else pass_cnt++;
        // Retire: hazard still visible this cycle, gone next cycle.
        retire_rd = 5'd5; retire_valid = 1'b1;
        #1;
        total_cnt++; if (dep_found !== 1'b1) $display("FAIL raw_same_cycle_dep: got %b want 1", dep_found); else pass_cnt++;
        tick();
        retire_valid = 1'b0;
        #1;
        total_cnt++; if (dep_found !== 1'b0) $display("FAIL raw_after_retire_dep: got %b want 0", dep_found); else pass_cnt++;
        total_cnt++; if (busy !== '0) $display("FAIL raw_after_retire_busy: got %h want 0", busy); else pass_cnt++;
        total_cnt++; if (error !== 1'b0) $display("FAIL raw_error: got %b want 0", error); else pass_cnt++;
        $display("test_raw done inflight=%0d", inflight);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 3; k++) issue_rd(5'd3);
        total_cnt++; if (inflight !== 7'd3) $display("FAIL sat_inflight: got %0d want 3", inflight); else pass_cnt++;
        rd = 5'd3; rd_valid = 1'b1;
        #1;
        total_cnt++; if (dep_found !== 1'b1) $display("FAIL sat_waw_dep: got %b want 1", dep_found); else pass_cnt++;
        total_cnt++; if (error !== 1'b0) $display("FAIL sat_error_before: got %b want 0", error); else pass_cnt++;
        issue = 1'b1;
        tick();
        issue = 1'b0;
        #1;
        total_cnt++; if (inflight !== 7'd3) $display("FAIL sat_inflight_held: got %0d want 3", inflight); else pass_cnt++;
        total_cnt++; if (error !== 1'b1) $display("FAIL sat_error_set: got %b want 1", error); else pass_cnt++;
        retire_rd = 5'd3; retire_valid = 1'b1;
        tick();
        retire_valid = 1'b0;
        #1;
        total_cnt++; if (dep_found !== 1'b0) $display("FAIL sat_unsat_dep: got %b want 0", dep_found); else pass_cnt++;
        total_cnt++; if (inflight !== 7'd2) $display("FAIL sat_inflight_after: got %0d want 2", inflight); else pass_cnt++;
        total_cnt++; if (error !== 1'b1) $display("FAIL sat_error_sticky: got %b want 1", error); else pass_cnt++;
        $display("test_saturation done");
    endtask

    task automatic test_same_cycle();
        do_reset();
        issue_rd(5'd7);
        rd = 5'd7; rd_valid = 1'b1; issue = 1'b1;
        retire_rd = 5'd7; retire_valid = 1'b1;
        tick();
        idle();
        #1;
        total_cnt++; if (inflight !== 7'd1) $display("FAIL same_inflight: got %0d want 1", inflight); else pass_cnt++;
        total_cnt++; if (busy !== 32'h0000_0080) $display("FAIL same_busy: got %h want 00000080", busy); else pass_cnt++;
        total_cnt++; if (error !== 1'b0) $display("FAIL same_error: got %b want 0", error); else pass_cnt++;
        kill_rd = 5'd7; kill_valid = 1'b1;
        retire_rd = 5'd7; retire_valid = 1'b1;
        tick();
        idle();
        #1;
        total_cnt++; if (busy !== '0) $display("FAIL under_busy: got %h want 0", busy); else pass_cnt++;
        total_cnt++; if (inflight !== 7'd0) $display("FAIL under_inflight: got %0d want 0", inflight); else pass_cnt++;
        total_cnt++; if (error !== 1'b1) $display("FAIL under_error: got %b want 1", error); else pass_cnt++;
        $display("test_same_cycle done");
    endtask

    task automatic test_kill();
        do_reset();
        issue_rd(5'd12);
        issue_rd(5'd20);
        kill_rd = 5'd12; kill_valid = 1'b1;
        tick();
        idle();
        #1;
        total_cnt++; if (busy !== 32'h0010_0000) $display("FAIL kill_busy: got %h want 00100000", busy); else pass_cnt++;
        total_cnt++; if (inflight !== 7'd1) $display("FAIL kill_inflight: got %0d want 1", inflight); else pass_cnt++;
        total_cnt++; if (error !== 1'b0) $display("FAIL kill_error: got %b want 0", error); else pass_cnt++;
        $display("test_kill done");
    endtask

    task automatic test_reg0();
        do_reset();
        rd = '0; rd_valid = 1'b1; issue = 1'b1;
        retire_rd = '0; retire_valid = 1'b1;
        kill_rd = '0; kill_valid = 1'b1;
        rs1 = '0; rs1_valid = 1'b1;
        #1;
        total_cnt++; if (dep_found !== 1'b0) $display("FAIL reg0_dep: got %b want 0", dep_found); else pass_cnt++;
        tick();
        tick();
        idle();
        #1;
        total_cnt++; if (inflight !== 7'd0) $display("FAIL reg0_inflight: got %0d want 0", inflight); else pass_cnt++;
        total_cnt++; if (busy !== '0) $display("FAIL reg0_busy: got %h want 0", busy); else pass_cnt++;
        total_cnt++; if (error !== 1'b0) $display("FAIL reg0_error: got %b want 0", error); else pass_cnt++;
        $display("test_reg0 done");
    endtask

    task automatic test_reset_priority();
        do_reset();
        issue_rd(5'd9);
        issue_rd(5'd9);
        total_cnt++; if (inflight !== 7'd2) $display("FAIL rstpri_pre_inflight: got %0d want 2", inflight); else pass_cnt++;
        rst = 1'b1;
        rd = 5'd9; rd_valid = 1'b1; issue = 1'b1;
        tick();
        idle();
        rs1 = 5'd9; rs1_valid = 1'b1;
        #1;
        total_cnt++; if (inflight !== 7'd0) $display("FAIL rstpri_inflight: got %0d want 0", inflight); else pass_cnt++;
        total_cnt++; if (busy !== '0) $display("FAIL rstpri_busy: got %h want 0", busy); else pass_cnt++;
        total_cnt++; if (error !== 1'b0) $display("FAIL rstpri_error: got %b want 0", error); else pass_cnt++;
        total_cnt++; if (dep_found !== 1'b0) $display("FAIL rstpri_dep: got %b want 0", dep_found); else pass_cnt++;
        $display("test_reset_priority done");
    endtask

    initial begin
        idle();
        test_reset();
        test_raw();
        test_saturation();
        test_same_cycle();
        test_kill();
        test_reg0();
        test_reset_priority();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
